// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse protocol layer: enables data reporting (0xF4), waits for the
// 0xFA acknowledge, then turns 3-byte stream packets into signed X/Y deltas
// and button state with a one-cycle done strobe.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SEND     | request transmission of 0xF4 (tx_wr_o follows one cycle later)
// WAIT_TX  | waiting for the transmitter to finish; received bytes ignored
// WAIT_ACK | waiting for 0xFA; resend on ack timeout
// BYTE1    | waiting for a header byte with the sync bit (bit3) set
// BYTE2    | waiting for the X low byte; packet timeout active
// BYTE3    | waiting for the Y low byte; packet timeout active
module ps2_mouse_packet #(
  parameter int CLK_HZ             = 100_000_000,
  parameter int ACK_TIMEOUT_CYCLES = CLK_HZ / 4,
  parameter int PKT_TIMEOUT_CYCLES = CLK_HZ / 50,
  parameter int TIMER_W            = 25
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  input  logic       tx_done_i,
  output logic [7:0] tx_data_o,
  output logic       tx_wr_o,
  output logic [8:0] x_o,
  output logic [8:0] y_o,
  output logic [2:0] btn_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    S_SEND,
    S_WAIT_TX,
    S_WAIT_ACK,
    S_BYTE1,
    S_BYTE2,
    S_BYTE3
  } state_t;

  // The timer is a down-counter loaded on state entry; reaching zero is the
  // same moment an up-counter cleared on entry would reach LIMIT-1.
  localparam logic [TIMER_W-1:0] ACK_LOAD = TIMER_W'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PKT_LOAD = TIMER_W'(PKT_TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         hdr_q, xlo_q;
  logic               latch_hdr, latch_xlo, emit;
  logic               timeout;
  logic [8:0]         x_q, y_q;
  logic [2:0]         btn_q;
  logic               done_q, tx_wr_q;

  assign timeout = (timer_q == '0);

  // Next-state decode; a received byte always takes priority over a timeout.
  always_comb begin
    state_d   = state_q;
    latch_hdr = 1'b0;
    latch_xlo = 1'b0;
    emit      = 1'b0;
    case (state_q)
      S_SEND:     state_d = S_WAIT_TX;
      S_WAIT_TX:  if (tx_done_i) state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (rx_done_i && rx_data_i == RSP_ACK) state_d = S_BYTE1;
        else if (timeout)                      state_d = S_SEND;
      end
      S_BYTE1: begin
        if (rx_done_i && rx_data_i[3]) begin
          latch_hdr = 1'b1;
          state_d   = S_BYTE2;
        end
      end
      S_BYTE2: begin
        if (rx_done_i) begin
          latch_xlo = 1'b1;
          state_d   = S_BYTE3;
        end else if (timeout) begin
          state_d = S_BYTE1;
        end
      end
      S_BYTE3: begin
        if (rx_done_i) begin
          emit    = 1'b1;
          state_d = S_BYTE1;
        end else if (timeout) begin
          state_d = S_BYTE1;
        end
      end
      default: state_d = S_SEND;
    endcase
  end

  // Timer reload on every state change, otherwise count down to zero and hold.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      case (state_d)
        S_WAIT_ACK:       timer_d = ACK_LOAD;
        S_BYTE2, S_BYTE3: timer_d = PKT_LOAD;
        default:          timer_d = '0;
      endcase
    end else if (!timeout) begin
      timer_d = timer_q - 1'b1;
    end
  end

  // State, timer and packet byte registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_SEND;
      timer_q <= '0;
      hdr_q   <= '0;
      xlo_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (latch_hdr) hdr_q <= rx_data_i;
      if (latch_xlo) xlo_q <= rx_data_i;
    end
  end

  // Registered outputs; an overflowed axis reports zero movement.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_q     <= '0;
      y_q     <= '0;
      btn_q   <= '0;
      done_q  <= 1'b0;
      tx_wr_q <= 1'b0;
    end else begin
      done_q  <= emit;
      tx_wr_q <= (state_q == S_SEND);
      if (emit) begin
        x_q   <= hdr_q[6] ? 9'd0 : {hdr_q[4], xlo_q};
        y_q   <= hdr_q[7] ? 9'd0 : {hdr_q[5], rx_data_i};
        btn_q <= hdr_q[2:0];
      end
    end
  end

  assign tx_data_o = CMD_ENABLE;
  assign tx_wr_o   = tx_wr_q;
  assign x_o       = x_q;
  assign y_o       = y_q;
  assign btn_o     = btn_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Bench for ps2_mouse_packet: directed protocol scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level model of the mouse link.
module tb_ps2_mouse_packet;

  localparam int ACK = 100;
  localparam int PKT = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic [8:0] x, y;
  logic [2:0] btn;
  logic       done;

  ps2_mouse_packet #(
    .CLK_HZ(1000),
    .ACK_TIMEOUT_CYCLES(ACK),
    .PKT_TIMEOUT_CYCLES(PKT),
    .TIMER_W(8)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .rx_data_i(rx_data),
    .rx_done_i(rx_done),
    .tx_done_i(tx_done),
    .tx_data_o(tx_data),
    .tx_wr_o(tx_wr),
    .x_o(x),
    .y_o(y),
    .btn_o(btn),
    .done_o(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Link model: 0 = command pending, 1 = transmitter busy,
  // 2 = waiting for acknowledge, 3 = streaming packets.
  int         link = 0;
  int         ack_age = 0;
  int         gap = 0;
  logic [7:0] pkt[$];
  logic [8:0] m_x = '0, m_y = '0;
  logic [2:0] m_btn = '0;
  logic       m_done = 1'b0, m_txwr = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      link = 0; ack_age = 0; gap = 0; pkt.delete();
      m_x = '0; m_y = '0; m_btn = '0; m_done = 1'b0; m_txwr = 1'b0;
    end else begin
      m_done = 1'b0;
      m_txwr = 1'b0;
      case (link)
        0: begin m_txwr = 1'b1; link = 1; end
        1: if (tx_done) begin link = 2; ack_age = 0; end
        2: begin
          if (rx_done && rx_data == 8'hFA) begin link = 3; pkt.delete(); end
          else if (ack_age == ACK - 1) link = 0;
          else ack_age++;
        end
        default: begin
          if (rx_done) begin
            if (pkt.size() != 0 || rx_data[3]) begin
              pkt.push_back(rx_data);
              gap = 0;
            end
            if (pkt.size() == 3) begin
              m_btn  = pkt[0][2:0];
              m_x    = pkt[0][6] ? 9'd0 : {pkt[0][4], pkt[1]};
              m_y    = pkt[0][7] ? 9'd0 : {pkt[0][5], pkt[2]};
              m_done = 1'b1;
              pkt.delete();
            end
          end else if (pkt.size() != 0) begin
            if (gap == PKT - 1) pkt.delete();
            else gap++;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, just after the edge.
  always @(posedge clk) begin
    #1;
    chk("x", 32'(x), 32'(m_x));
    chk("y", 32'(y), 32'(m_y));
    chk("btn", 32'(btn), 32'(m_btn));
    chk("done", 32'(done), 32'(m_done));
    chk("tx_wr", 32'(tx_wr), 32'(m_txwr));
    chk("tx_data", 32'(tx_data), 32'h0000_00F4);
    if (done) done_count++;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns the cycle number at which tx_wr was seen high, -1 on expiry.
  task automatic wait_txwr(input int max_cycles, output int at);
    at = -1;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (tx_wr) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL wait_txwr: got no tx_wr within %0d cycles", max_cycles);
    end
    @(negedge clk);
  endtask

  int rel, t0, t1, dc, r;
  logic [7:0] b;

  initial begin
    // Reset and first command request.
    idle(3);
    reset = 1'b0;
    rel = cyc;
    #1;
    chk("rst_tx_wr", 32'(tx_wr), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_btn", 32'(btn), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h0000_00F4);
    wait_txwr(5, t1);
    chk("txwr_latency", 32'(t1 - rel), 32'd1);

    // Lost acknowledge: a non-FA byte is ignored, then the command is resent.
    // The SEND state starts ACK cycles after tx_done; tx_wr is visible one later.
    t0 = cyc + 1;
    pulse_tx();
    send_byte(8'h00);
    wait_txwr(ACK + 20, t1);
    chk("ack_timeout_retry", 32'(t1 - t0), 32'(ACK + 1));

    // Successful handshake.
    pulse_tx();
    send_byte(8'hFA);
    idle(3);
    chk("no_done_after_ack", 32'(done_count), 32'd0);

    // Packet decode with negative X.
    dc = done_count;
    send_byte(8'h19); send_byte(8'h05); send_byte(8'hFE);
    idle(2);
    chk("pkt1_x", 32'(x), 32'h105);
    chk("pkt1_y", 32'(y), 32'h0FE);
    chk("pkt1_btn", 32'(btn), 32'd1);
    chk("pkt1_done_cnt", 32'(done_count - dc), 32'd1);

    // Unsynchronised byte dropped, then an X-overflow packet.
    dc = done_count;
    send_byte(8'h10);
    send_byte(8'h4A); send_byte(8'h7F); send_byte(8'h03);
    idle(2);
    chk("ovf_x", 32'(x), 32'd0);
    chk("ovf_y", 32'(y), 32'd3);
    chk("ovf_btn", 32'(btn), 32'd2);
    chk("ovf_done_cnt", 32'(done_count - dc), 32'd1);

    // Stale header discarded after the inter-byte timeout.
    dc = done_count;
    send_byte(8'h08);
    idle(PKT + 5);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
    idle(2);
    chk("to_x", 32'(x), 32'd1);
    chk("to_y", 32'(y), 32'd2);
    chk("to_done_cnt", 32'(done_count - dc), 32'd1);

    // Asynchronous reset in the middle of a packet.
    send_byte(8'h08); send_byte(8'h01);
    reset = 1'b1;
    #1;
    chk("midrst_x", 32'(x), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_btn", 32'(btn), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    wait_txwr(5, t1);
    chk("midrst_txwr_latency", 32'(t1 - rel), 32'd1);

    // Randomized traffic, checked by the every-cycle compare.
    pulse_tx();
    send_byte(8'hFA);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        case ($urandom_range(0, 3))
          0:       b = 8'($urandom_range(0, 255)) | 8'h08;
          1:       b = 8'hFA;
          default: b = 8'($urandom_range(0, 255));
        endcase
        send_byte(b);
      end else if (r < 65) begin
        pulse_tx();
      end else if (r < 85) begin
        idle($urandom_range(1, PKT + 5));
      end else if (r < 87) begin
        pulse_reset();
      end else begin
        idle(1);
      end
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
